exe_stage: RTL and testbench

- Execute stage of the 5-stage LoongArch-subset pipeline; sits directly downstream of the decode stage and upstream of the memory stage.
- Holds the 151-bit decode bundle in a valid/allowin pipeline register and evaluates the 12-op ALU.
- Issues the word load/store request to the synchronous data SRAM.
- Forwards a 71-bit bundle to MEM, and exports destination info for load-use hazard detection.

---
 rtl/exe_stage_pkg.sv | 51 +++++
 rtl/exe_stage_if.sv | 24 ++
 rtl/exe_stage_alu.sv | 38 +++
 rtl/exe_stage.sv | 73 +++++++
 tb/tb_exe_stage.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared types for the execute stage: decode/mem bundle layouts,
// ALU op bit indices and the hazard-info layout.
package exe_stage_pkg;

   localparam int ID_W  = 151;
   localparam int MEM_W = 71;
   localparam int HAZ_W = 7;

   localparam int ALU_N    = 12;
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   // First member is the MSB: pc sits at [150:119].
   typedef struct packed {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rkd_value;
      logic        res_from_mem;
      logic [3:0]  mem_we;
      logic [11:0] alu_op;
      logic [31:0] alu_src1;
      logic [31:0] alu_src2;
   } id_ex_t;

   // pc at [70:39], alu_result at [31:0].
   typedef struct packed {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic        res_from_mem;
      logic [31:0] alu_result;
   } ex_mem_t;

   typedef struct packed {
      logic       rf_we;
      logic       load;
      logic [4:0] rf_waddr;
   } haz_t;

endpackage

// File: rtl/exe_stage_if.sv
// Data SRAM request bus driven by the execute stage.
// master: exe_stage drives en/we/addr/wdata; slave: the SRAM side.
interface exe_stage_if;

   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;

   modport master (
      output data_sram_en,
      output data_sram_we,
      output data_sram_addr,
      output data_sram_wdata
   );

   modport slave (
      input data_sram_en,
      input data_sram_we,
      input data_sram_addr,
      input data_sram_wdata
   );

endinterface

// File: rtl/exe_stage_alu.sv
// 12-op combinational ALU, one-hot alu_op.
// Ports: alu_op, alu_src1, alu_src2 -> alu_result.
module alu
   import exe_stage_pkg::*;
(
   input  logic [11:0] alu_op,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);

   logic [31:0] r [ALU_N];
   logic [4:0]  sa;

   assign sa = alu_src2[4:0];

   // Each op result is masked by its select bit and OR-ed, so an
   // all-zero op gives 0 and no priority is implied.
   always_comb begin
      r[ALU_ADD]  = alu_src1 + alu_src2;
      r[ALU_SUB]  = alu_src1 - alu_src2;
      r[ALU_SLT]  = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      r[ALU_SLTU] = {31'd0, alu_src1 < alu_src2};
      r[ALU_AND]  = alu_src1 & alu_src2;
      r[ALU_NOR]  = ~(alu_src1 | alu_src2);
      r[ALU_OR]   = alu_src1 | alu_src2;
      r[ALU_XOR]  = alu_src1 ^ alu_src2;
      r[ALU_SLL]  = alu_src1 << sa;
      r[ALU_SRL]  = alu_src1 >> sa;
      r[ALU_SRA]  = $unsigned($signed(alu_src1) >>> sa);
      r[ALU_LUI]  = alu_src2;
      alu_result = '0;
      for (int i = 0; i < ALU_N; i++) begin
         alu_result = alu_result | (r[i] & {32{alu_op[i]}});
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: valid/allowin register for the decode bundle, ALU,
// data SRAM request, MEM bundle and hazard info out.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               ID_to_EXE_valid,
   input  logic [ID_W-1:0]    ID_signal,
   input  logic               MEM_allowin,
   output logic               EXE_allowin,
   output logic               EXE_to_MEM_valid,
   output logic [MEM_W-1:0]   MEM_signal,
   output logic [HAZ_W-1:0]   EXE_hazard_signal,
   exe_stage_if.master        sram
);

   id_ex_t      bundle;
   logic        exe_valid;
   logic        exe_readygo;
   logic [31:0] alu_result;
   logic        mem_req;
   ex_mem_t     mem_out;
   haz_t        haz;

   assign exe_readygo = 1'b1;
   assign EXE_allowin = !exe_valid
                      | (exe_readygo & MEM_allowin);
   assign EXE_to_MEM_valid = exe_valid & exe_readygo;

   // Invalid input still advances exe_valid but keeps old contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exe_valid <= 1'b0;
         bundle    <= '0;
      end else if (EXE_allowin) begin
         exe_valid <= ID_to_EXE_valid;
         if (ID_to_EXE_valid) begin
            bundle <= ID_signal;
         end
      end
   end

   alu u_alu (
      .alu_op     (bundle.alu_op),
      .alu_src1   (bundle.alu_src1),
      .alu_src2   (bundle.alu_src2),
      .alu_result (alu_result)
   );

   assign mem_out.pc           = bundle.pc;
   assign mem_out.rf_we        = bundle.rf_we;
   assign mem_out.rf_waddr     = bundle.rf_waddr;
   assign mem_out.res_from_mem = bundle.res_from_mem;
   assign mem_out.alu_result   = alu_result;
   assign MEM_signal = mem_out;

   assign haz.rf_we    = exe_valid & bundle.rf_we;
   assign haz.load     = exe_valid & bundle.res_from_mem;
   assign haz.rf_waddr = bundle.rf_waddr;
   assign EXE_hazard_signal = haz;

   // Request only on the cycle the bundle leaves, so a stalled
   // store never writes twice.
   assign mem_req = exe_valid
                  & (bundle.res_from_mem | (|bundle.mem_we));
   assign sram.data_sram_en    = mem_req & MEM_allowin;
   assign sram.data_sram_we    = sram.data_sram_en
                               ? bundle.mem_we : 4'h0;
   assign sram.data_sram_addr  = alu_result;
   assign sram.data_sram_wdata = bundle.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_exe_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         ID_to_EXE_valid;
   logic [150:0] ID_signal;
   logic         MEM_allowin;
   logic         EXE_allowin;
   logic         EXE_to_MEM_valid;
   logic [70:0]  MEM_signal;
   logic [6:0]   EXE_hazard_signal;

   exe_stage_if sram ();

   exe_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ID_to_EXE_valid   (ID_to_EXE_valid),
      .ID_signal         (ID_signal),
      .MEM_allowin       (MEM_allowin),
      .EXE_allowin       (EXE_allowin),
      .EXE_to_MEM_valid  (EXE_to_MEM_valid),
      .MEM_signal        (MEM_signal),
      .EXE_hazard_signal (EXE_hazard_signal),
      .sram              (sram)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int drains = 0;

   logic         m_valid;
   logic [150:0] m_bundle;
   logic [31:0]  pcq [$];

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(
      input logic [11:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
      logic [31:0] res;
      logic signed [31:0] sa;
      int sh;
      res = 0;
      sa  = a;
      sh  = int'(b[4:0]);
      if (op[0])  res |= a + b;
      if (op[1])  res |= a - b;
      if (op[2])  res |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (op[3])  res |= (a < b) ? 32'd1 : 32'd0;
      if (op[4])  res |= a & b;
      if (op[5])  res |= ~(a | b);
      if (op[6])  res |= a | b;
      if (op[7])  res |= a ^ b;
      if (op[8])  res |= a << sh;
      if (op[9])  res |= a >> sh;
      if (op[10]) res |= 32'(sa >>> sh);
      if (op[11]) res |= b;
      return res;
   endfunction

   function automatic logic [150:0] mk(
      input logic [31:0] pc, input logic we,
      input logic [4:0] wa, input logic [31:0] rkd,
      input logic rfm, input logic [3:0] mwe,
      input logic [11:0] op, input logic [31:0] s1,
      input logic [31:0] s2);
      return {pc, we, wa, rkd, rfm, mwe, op, s1, s2};
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [150:0] rnd_bundle();
      logic [11:0] op;
      logic [3:0]  mwe;
      int k;
      k = $urandom_range(0, 15);
      if (k < 12) op = 12'(1 << k);
      else if (k == 12) op = 12'h0;
      else op = 12'($urandom);
      mwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      return mk($urandom, 1'($urandom), 5'($urandom), $urandom,
                1'($urandom), mwe, op, rnd_val(), rnd_val());
   endfunction

   // Checks all outputs against the model, then advances the model
   // to the state it must hold after the coming edge.
   task automatic model_step();
      logic [31:0] pc, rkd, s1, s2, r;
      logic        we, rfm, req, en;
      logic [4:0]  wa;
      logic [3:0]  mwe;
      logic [11:0] op;
      pc  = m_bundle[150:119];
      we  = m_bundle[118];
      wa  = m_bundle[117:113];
      rkd = m_bundle[112:81];
      rfm = m_bundle[80];
      mwe = m_bundle[79:76];
      op  = m_bundle[75:64];
      s1  = m_bundle[63:32];
      s2  = m_bundle[31:0];
      r   = ref_alu(op, s1, s2);
      req = m_valid && (rfm || (mwe != 0));
      en  = req && MEM_allowin;
      chk("allowin", EXE_allowin, !m_valid || MEM_allowin);
      chk("to_mem_valid", EXE_to_MEM_valid, m_valid);
      chk("mem_signal", MEM_signal, {pc, we, wa, rfm, r});
      chk("hazard", EXE_hazard_signal,
          {m_valid & we, m_valid & rfm, wa});
      chk("sram_en", sram.data_sram_en, en);
      chk("sram_we", sram.data_sram_we, en ? mwe : 4'h0);
      chk("sram_addr", sram.data_sram_addr, r);
      chk("sram_wdata", sram.data_sram_wdata, rkd);
      if (m_valid && MEM_allowin) begin
         drains++;
         if (pcq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL order: drain with empty queue");
         end else begin
            chk("order_pc", pc, pcq.pop_front());
         end
      end
      if (!m_valid || MEM_allowin) begin
         m_valid = ID_to_EXE_valid;
         if (ID_to_EXE_valid) begin
            m_bundle = ID_signal;
            pcq.push_back(ID_signal[150:119]);
         end
      end
   endtask

   task automatic drive(input logic v, input logic [150:0] s,
                        input logic ma);
      @(negedge clk);
      ID_to_EXE_valid = v;
      ID_signal       = s;
      MEM_allowin     = ma;
      #4;
      model_step();
   endtask

   task automatic commit();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, input logic [150:0] s,
                       input logic ma);
      drive(v, s, ma);
      commit();
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_allowin"}, EXE_allowin, 1'b1);
      chk({nm, "_valid"}, EXE_to_MEM_valid, 1'b0);
      chk({nm, "_mem"}, MEM_signal, 71'h0);
      chk({nm, "_haz"}, EXE_hazard_signal, 7'h0);
      chk({nm, "_en"}, sram.data_sram_en, 1'b0);
      chk({nm, "_we"}, sram.data_sram_we, 4'h0);
      chk({nm, "_addr"}, sram.data_sram_addr, 32'h0);
      chk({nm, "_wdata"}, sram.data_sram_wdata, 32'h0);
   endtask

   logic [11:0] t_op [7];
   logic [31:0] t_a  [7];
   logic [31:0] t_b  [7];
   logic [31:0] t_r  [7];

   initial begin
      reset           = 1'b0;
      ID_to_EXE_valid = 1'b1;
      ID_signal       = mk(32'h1c00_0000, 1'b1, 5'd3, 32'h55,
                           1'b1, 4'hF, 12'h1, 32'h1, 32'h2);
      MEM_allowin     = 1'b0;
      m_valid         = 1'b0;
      m_bundle        = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      reset           = 1'b1;
      ID_to_EXE_valid = 1'b0;

      // invalid input with garbage payload
      step(1'b0, {5{32'hA5A5_5A5A}}, 1'b1);
      chk("inv_valid", EXE_to_MEM_valid, 1'b0);
      chk("inv_haz_we", EXE_hazard_signal[6], 1'b0);
      chk("inv_en", sram.data_sram_en, 1'b0);

      // ALU sweep with literal results
      t_op[0] = 12'h001; t_a[0] = 32'h7FFF_FFFF;
      t_b[0] = 32'h1;    t_r[0] = 32'h8000_0000;
      t_op[1] = 12'h002; t_a[1] = 32'h0;
      t_b[1] = 32'h1;    t_r[1] = 32'hFFFF_FFFF;
      t_op[2] = 12'h004; t_a[2] = 32'hFFFF_FFFF;
      t_b[2] = 32'h1;    t_r[2] = 32'h1;
      t_op[3] = 12'h008; t_a[3] = 32'hFFFF_FFFF;
      t_b[3] = 32'h1;    t_r[3] = 32'h0;
      t_op[4] = 12'h020; t_a[4] = 32'h0;
      t_b[4] = 32'h0;    t_r[4] = 32'hFFFF_FFFF;
      t_op[5] = 12'h400; t_a[5] = 32'h8000_0000;
      t_b[5] = 32'h24;   t_r[5] = 32'hF800_0000;
      t_op[6] = 12'h800; t_a[6] = 32'hDEAD_0000;
      t_b[6] = 32'h1234_5000; t_r[6] = 32'h1234_5000;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, mk(32'h100 + 32'(i), 1'b1, 5'd1, 32'h0,
                       1'b0, 4'h0, t_op[i], t_a[i], t_b[i]), 1'b1);
         chk($sformatf("alu_%0d", i), MEM_signal[31:0], t_r[i]);
      end

      // store issued for exactly one cycle
      step(1'b1, mk(32'h1c00_0100, 1'b0, 5'd0, 32'hDEAD_BEEF,
                    1'b0, 4'hF, 12'h001, 32'h1000, 32'h8), 1'b1);
      chk("st_en", sram.data_sram_en, 1'b1);
      chk("st_we", sram.data_sram_we, 4'hF);
      chk("st_addr", sram.data_sram_addr, 32'h1008);
      chk("st_wdata", sram.data_sram_wdata, 32'hDEAD_BEEF);
      step(1'b0, rnd_bundle(), 1'b1);
      chk("st_once", sram.data_sram_en, 1'b0);

      // load stalled three cycles, then drained
      step(1'b1, mk(32'h1c00_0200, 1'b1, 5'd5, 32'h0,
                    1'b1, 4'h0, 12'h001, 32'h2000, 32'h4), 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_allowin", EXE_allowin, 1'b0);
         chk("stall_en", sram.data_sram_en, 1'b0);
         chk("stall_mem", MEM_signal,
             {32'h1c00_0200, 1'b1, 5'd5, 1'b1, 32'h2004});
         chk("stall_haz", EXE_hazard_signal, 7'b11_00101);
         step(1'($urandom), rnd_bundle(), 1'b0);
      end
      drive(1'b0, rnd_bundle(), 1'b1);
      chk("drain_en", sram.data_sram_en, 1'b1);
      chk("drain_we", sram.data_sram_we, 4'h0);
      commit();
      chk("drain_gone", EXE_to_MEM_valid, 1'b0);

      // back-to-back, no bubbles
      drains = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, mk(32'h200 + 32'(4 * i), 1'b1, 5'(i), 32'h0,
                       1'b0, 4'h0, 12'h040, 32'(i), 32'h0), 1'b1);
         chk("b2b_valid", EXE_to_MEM_valid, 1'b1);
         chk("b2b_pc", MEM_signal[70:39], 32'h200 + 32'(4 * i));
      end
      step(1'b0, rnd_bundle(), 1'b1);
      chk("b2b_drains", drains, 4);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom), rnd_bundle(),
              $urandom_range(0, 9) < 7);
      end

      // reset while a store is stalled
      step(1'b1, mk(32'h1c00_0300, 1'b0, 5'd0, 32'h1111_2222,
                    1'b0, 4'h3, 12'h001, 32'h40, 32'h0), 1'b0);
      @(negedge clk);
      reset           = 1'b0;
      ID_to_EXE_valid = 1'b1;
      ID_signal       = rnd_bundle();
      MEM_allowin     = 1'b1;
      #1;
      chk_all_zero("midrst");
      m_valid  = 1'b0;
      m_bundle = '0;
      pcq.delete();
      @(posedge clk);
      #1;
      chk("midrst_en", sram.data_sram_en, 1'b0);
      chk("midrst_valid", EXE_to_MEM_valid, 1'b0);
      @(negedge clk);
      reset           = 1'b1;
      ID_to_EXE_valid = 1'b1;
      ID_signal       = mk(32'h1c00_0400, 1'b1, 5'd7, 32'h0,
                           1'b0, 4'h0, 12'h001, 32'h3, 32'h4);
      MEM_allowin     = 1'b1;
      #4;
      model_step();
      commit();
      chk("post_rst_valid", EXE_to_MEM_valid, 1'b1);
      chk("post_rst_res", MEM_signal[31:0], 32'h7);
      step(1'b0, rnd_bundle(), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
